sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Multi-cycle memory-stage controller between EXE_Stage_Reg outputs and an off-chip 16-bit SRAM; it replaces the single-cycle data memory inside the MEM stage.
- Splits each 32-bit load/store into two 16-bit SRAM accesses.
- Drops ready while busy; the top level ORs ~ready into freeze, stalling every pipeline register until the access completes.
- Read data feeds MEM_Stage_Reg Mem_read_value_in.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3, cycles each 16-bit phase holds address/control stable (>=1).
- SRAM_ADDR_W, 18, SRAM halfword address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request (from EXE stage register).
- MEM_W_EN  in  1  store request.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value (ST_val).
- read_data  out  32  assembled load value.
- ready  out  1  0 = stall pipeline; 1 = access done or idle.
- SRAM_ADDR  out  SRAM_ADDR_W  halfword address.
- SRAM_DQ_out  out  16  write data to pad.
- SRAM_DQ_oe  out  1  drive enable for DQ pad.
- SRAM_DQ_in  in  16  read data from pad.
- SRAM_WE_N  out  1  active-low write strobe.

Behaviour:
- Address map:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits.
  - Low half at SRAM_ADDR = {word,1'b0}; high half at {word,1'b1}.
  - Out-of-range addresses wrap modulo SRAM size; no error flag.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - MEM_W_EN or MEM_R_EN high -> latch address, write_data and op; go to LO. Write wins if both are high.
  - Otherwise stay in IDLE.
- LO and HI:
  - Each lasts exactly WAIT_CYCLES cycles, counted by a wait counter that restarts at phase entry.
  - After the last cycle, LO -> HI and HI -> DONE.
- DONE: lasts 1 cycle, then -> IDLE unconditionally. The pipeline advances on that edge, so the same request is never re-issued.
- ready (combinational): 1 when (IDLE and no request) or DONE; 0 otherwise, including the IDLE cycle in which a request first appears.
- Latency: request visible in IDLE at cycle 0 -> DONE (ready=1) at cycle 1+2*WAIT_CYCLES, i.e. cycle 7 at default.
- Writes:
  - SRAM_DQ_oe=1 and SRAM_WE_N=0 throughout LO and HI.
  - SRAM_DQ_out = write_data[15:0] in LO, [31:16] in HI.
  - SRAM_WE_N=1 in IDLE and DONE.
- Reads:
  - SRAM_DQ_oe=0 and SRAM_WE_N=1.
  - SRAM_DQ_in is sampled on the last cycle of LO into read_data[15:0], and on the last cycle of HI into read_data[31:16].
  - read_data holds its value until the next read completes; writes do not change it.
- SRAM_ADDR is held stable for the whole phase; in IDLE and DONE it holds the last value.
- Reset (any time, including mid-access):
  - State -> IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1.
  - ready follows the IDLE rule.
  - A partially written word is left as-is in SRAM; no rollback.
- Requests that change during LO/HI are ignored; latched values rule.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LO, HI, DONE);
  - BASE_ADDR default;
  - SRAM data width constant (16).
- No RTL sub-module; the wait counter and FSM live in one module.
- The bench uses a behavioural sram_model (array of 2^SRAM_ADDR_W halfwords, write on WE_N low, combinational read).

Test Plan:
- Store: W_EN=1, address=1024, data=0xDEADBEEF.
  - ready low for cycles 0..6, high at 7.
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - WE_N low for exactly 6 cycles.
- Load back: R_EN=1, address=1024 -> read_data=0xDEADBEEF in DONE cycle 7; WE_N never low.
- Address mapping: store 0x12345678 at 1032 -> SRAM[4]=0x5678, SRAM[5]=0x1234; load from 1028 returns the prior word unchanged.
- Back-to-back: load immediately after store (request held continuously) -> two 7-cycle stalls; exactly 2 DONE pulses; correct data.
- Reset mid-write in HI phase:
  - outputs return to reset values asynchronously;
  - SRAM low half updated, high half old;
  - next request completes normally.
- Both enables high with WAIT_CYCLES=1: write performed, DONE at cycle 3, read_data unchanged.

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// Purpose : shared types and constants for the 16-bit SRAM memory-stage controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: FSM state enum, default base address of the SRAM window, SRAM data width.
package sram_mem_controller_pkg;

    // Byte address that maps onto SRAM halfword 0.
    localparam int unsigned DEF_BASE_ADDR = 1024;

    // Width of the off-chip SRAM data bus.
    localparam int unsigned SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_mem_controller.sv
// Purpose : MEM-stage controller that splits each 32-bit load/store into two 16-bit SRAM accesses.
// Latency : request seen in IDLE at cycle 0 -> DONE (ready=1) at cycle 1+2*WAIT_CYCLES.
// Backpr. : ready drops from the first request cycle until DONE; the pipeline freezes on ~ready.
//
// Ports:
//   clk, rst                 pipeline clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN       load / store request (store wins when both are high)
//   address, write_data      byte address and store value from the EXE stage register
//   read_data                assembled load value, updated only when a load completes
//   ready                    0 = stall pipeline, 1 = idle or access done
//   SRAM_ADDR                halfword address to the SRAM
//   SRAM_DQ_out/_oe/_in      bidirectional data pad split into out, enable and in
//   SRAM_WE_N                active-low write strobe
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0]     SRAM_DQ_out,
    output logic                   SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0]     SRAM_DQ_in,
    output logic                   SRAM_WE_N
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                   state_q, state_n;
    logic [CNT_W-1:0]         cnt_q;
    logic                     op_wr_q;
    logic [SRAM_DW-1:0]       wdata_hi_q;
    logic [SRAM_ADDR_W-2:0]   word_q;
    logic [SRAM_DW-1:0]       rd_lo_q;

    logic                     req;
    logic                     phase_last;
    logic [31:0]              offset;
    logic [SRAM_ADDR_W-2:0]   word_in;
    logic                     addr_unused;

    assign req        = MEM_R_EN | MEM_W_EN;
    assign phase_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    // Word index inside the SRAM window; bits above the SRAM size are dropped so
    // out-of-range addresses simply wrap.
    assign offset      = address - BASE_ADDR;
    assign word_in     = offset[SRAM_ADDR_W:2];
    assign addr_unused = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n    = state_q;
        ready      = 1'b0;
        SRAM_WE_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_n = LO;
                end else begin
                    ready = 1'b1;
                end
            end
            LO: begin
                SRAM_WE_N  = ~op_wr_q;
                SRAM_DQ_oe = op_wr_q;
                if (phase_last) begin
                    state_n = HI;
                end
            end
            HI: begin
                SRAM_WE_N  = ~op_wr_q;
                SRAM_DQ_oe = op_wr_q;
                if (phase_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                // The pipeline advances on this edge, so going straight back to
                // IDLE never re-issues the same request.
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: restarts at every phase entry, idles at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == LO) || (state_q == HI)) begin
            cnt_q <= phase_last ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Request latch and SRAM address/data registers.
    // SRAM_ADDR and SRAM_DQ_out are loaded on the edge that enters a phase,
    // so they are stable for the whole phase and hold in IDLE/DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr_q     <= 1'b0;
            wdata_hi_q  <= '0;
            word_q      <= '0;
            rd_lo_q     <= '0;
            read_data   <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_wr_q    <= MEM_W_EN;
                        wdata_hi_q <= write_data[31:16];
                        word_q     <= word_in;
                        SRAM_ADDR  <= {word_in, 1'b0};
                        if (MEM_W_EN) begin
                            SRAM_DQ_out <= write_data[15:0];
                        end
                    end
                end
                LO: begin
                    if (phase_last) begin
                        SRAM_ADDR <= {word_q, 1'b1};
                        if (op_wr_q) begin
                            SRAM_DQ_out <= wdata_hi_q;
                        end else begin
                            rd_lo_q <= SRAM_DQ_in;
                        end
                    end
                end
                HI: begin
                    // The low half is staged so read_data changes only when the
                    // whole word is available.
                    if (phase_last && !op_wr_q) begin
                        read_data <= {SRAM_DQ_in, rd_lo_q};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Purpose : directed self-checking bench for sram_mem_controller with behavioural SRAMs.
// Latency : expects DONE at cycle 1+2*WAIT_CYCLES after a request (7 default, 3 for WAIT_CYCLES=1).
// Backpr. : requests are held until ready is seen, then dropped (or replaced) after that edge.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst;

    // Instance 0: default parameters
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    // Instance 1: WAIT_CYCLES = 1
    logic        r_en2, w_en2;
    logic [31:0] addr2, wdata2, rd2;
    logic        ready2;
    logic [17:0] sram_addr2;
    logic [15:0] dq_out2, dq_in2;
    logic        dq_oe2, we_n2;

    logic [15:0] mem  [0:(1<<18)-1];
    logic [15:0] mem2 [0:(1<<18)-1];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    sram_mem_controller dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_ADDR(sram_addr), .SRAM_DQ_out(sram_dq_out), .SRAM_DQ_oe(sram_dq_oe),
        .SRAM_DQ_in(sram_dq_in), .SRAM_WE_N(sram_we_n)
    );

    sram_mem_controller #(.WAIT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst),
        .MEM_R_EN(r_en2), .MEM_W_EN(w_en2),
        .address(addr2), .write_data(wdata2),
        .read_data(rd2), .ready(ready2),
        .SRAM_ADDR(sram_addr2), .SRAM_DQ_out(dq_out2), .SRAM_DQ_oe(dq_oe2),
        .SRAM_DQ_in(dq_in2), .SRAM_WE_N(we_n2)
    );

    // Behavioural SRAMs: combinational read, write while WE_N is low (sampled mid-cycle).
    assign sram_dq_in = mem[sram_addr];
    assign dq_in2     = mem2[sram_addr2];

    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr] = sram_dq_out;
        if (!we_n2)     mem2[sram_addr2] = dq_out2;
        if (ready && (mem_r_en || mem_w_en)) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request to the chosen instance, wait for ready (bounded),
    // then advance one edge. Returns latency, WE_N-low cycle count and the
    // read_data seen in the DONE cycle.
    task automatic op(input int inst, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d, input bit hold,
                      output int lat, output int we_low, output logic [31:0] rd);
        if (inst == 0) begin
            mem_w_en = w; mem_r_en = r; address = a; write_data = d;
        end else begin
            w_en2 = w; r_en2 = r; addr2 = a; wdata2 = d;
        end
        lat = -1; we_low = 0; rd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((inst == 0) ? !sram_we_n : !we_n2) we_low++;
            if ((inst == 0) ? ready : ready2) begin
                lat = c;
                rd  = (inst == 0) ? read_data : rd2;
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) begin
            if (inst == 0) begin mem_w_en = 1'b0; mem_r_en = 1'b0; end
            else begin w_en2 = 1'b0; r_en2 = 1'b0; end
        end
    endtask

    initial begin
        int          lat, wl, d0;
        logic [31:0] rd;

        for (int i = 0; i < (1 << 18); i++) begin
            mem[i]  = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem[2]  = 16'h5A5A; mem[3]  = 16'hA5A5;
        mem[20] = 16'h1111; mem[21] = 16'h2222;

        rst = 1'b1;
        mem_r_en = 0; mem_w_en = 0; address = 0; write_data = 0;
        r_en2 = 0; w_en2 = 0; addr2 = 0; wdata2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n",  {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe",    {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_addr",  {14'd0, sram_addr}, 32'd0);
        chk("rst_dqout", {16'd0, sram_dq_out}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1024
        op(0, 1, 0, 32'd1024, 32'hDEADBEEF, 0, lat, wl, rd);
        chk("st_latency", lat, 32'd7);
        chk("st_we_low",  wl, 32'd6);
        chk("st_mem0",    {16'd0, mem[0]}, 32'h0000BEEF);
        chk("st_mem1",    {16'd0, mem[1]}, 32'h0000DEAD);
        chk("st_rd_keep", rd, 32'd0);

        // Load it back
        op(0, 0, 1, 32'd1024, 32'h0, 0, lat, wl, rd);
        chk("ld_latency", lat, 32'd7);
        chk("ld_we_low",  wl, 32'd0);
        chk("ld_data",    rd, 32'hDEADBEEF);

        // Address mapping
        op(0, 1, 0, 32'd1032, 32'h12345678, 0, lat, wl, rd);
        chk("map_mem4", {16'd0, mem[4]}, 32'h00005678);
        chk("map_mem5", {16'd0, mem[5]}, 32'h00001234);
        chk("map_rd_keep", rd, 32'hDEADBEEF);
        op(0, 0, 1, 32'd1028, 32'h0, 0, lat, wl, rd);
        chk("map_ld1028", rd, 32'hA5A55A5A);

        // Back-to-back: store then load with the request held across the DONE edge
        d0 = done_cnt;
        op(0, 1, 0, 32'd1048, 32'hCAFEBABE, 1, lat, wl, rd);
        chk("b2b_st_lat", lat, 32'd7);
        op(0, 0, 1, 32'd1048, 32'h0, 0, lat, wl, rd);
        chk("b2b_ld_lat", lat, 32'd7);
        chk("b2b_ld_data", rd, 32'hCAFEBABE);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_dones", done_cnt - d0, 32'd2);

        // Reset during the high-half write
        mem_w_en = 1'b1; address = 32'd1064; write_data = 32'hAAAABBBB;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_hi_addr", {14'd0, sram_addr}, 32'd21);
        chk("mid_hi_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1; mem_w_en = 1'b0;
        #1;
        chk("arst_we_n",  {31'd0, sram_we_n}, 32'd1);
        chk("arst_oe",    {31'd0, sram_dq_oe}, 32'd0);
        chk("arst_addr",  {14'd0, sram_addr}, 32'd0);
        chk("arst_dqout", {16'd0, sram_dq_out}, 32'd0);
        chk("arst_rdata", read_data, 32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_mem_lo", {16'd0, mem[20]}, 32'h0000BBBB);
        chk("arst_mem_hi", {16'd0, mem[21]}, 32'h00002222);
        op(0, 0, 1, 32'd1064, 32'h0, 0, lat, wl, rd);
        chk("post_rst_lat",  lat, 32'd7);
        chk("post_rst_data", rd, 32'h2222BBBB);

        // Both enables high, WAIT_CYCLES = 1: store wins
        op(1, 1, 1, 32'd1024, 32'h0BADF00D, 0, lat, wl, rd);
        chk("w1_latency", lat, 32'd3);
        chk("w1_we_low",  wl, 32'd2);
        chk("w1_rd_keep", rd, 32'd0);
        chk("w1_mem0",    {16'd0, mem2[0]}, 32'h0000F00D);
        chk("w1_mem1",    {16'd0, mem2[1]}, 32'h00000BAD);
        chk("w1_oe_idle", {31'd0, dq_oe2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
